// File: rtl/bht_sat_predictor_pkg.sv
// Shared constants and counter arithmetic for the saturating-counter branch predictor.
// Counter helpers work on a 4-bit carrier (widest legal counter); callers truncate to CTR_BITS.
package bht_sat_predictor_pkg;

    localparam int STAT_W       = 32;
    localparam int CTR_MAX_BITS = 4;

    // Weakly not-taken: 2^(bits-1)-1, which is 0 for a 1-bit counter.
    function automatic logic [CTR_MAX_BITS-1:0] ctr_reset_val(input int unsigned bits);
        return CTR_MAX_BITS'((1 << (bits - 1)) - 1);
    endfunction

    function automatic logic [CTR_MAX_BITS-1:0] sat_step(input logic [CTR_MAX_BITS-1:0] ctr,
                                                         input logic                    up,
                                                         input int unsigned             bits);
        logic [CTR_MAX_BITS-1:0] ceil;
        ceil = CTR_MAX_BITS'((1 << bits) - 1);
        if (up)
            return (ctr == ceil) ? ceil : ctr + 4'd1;
        else
            return (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/bht_sat_predictor_table.sv
// Counter storage: ENTRIES saturating counters, one combinational read port and one
// read-modify-write update port. The read port always sees the pre-update contents.
module sat_counter_table
    import bht_sat_predictor_pkg::*;
#(
    parameter  int ENTRIES  = 64,
    parameter  int CTR_BITS = 2,
    localparam int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_up
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_reset_val(CTR_BITS));

    logic [CTR_BITS-1:0] mem [ENTRIES];

    assign rd_ctr = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= CTR_INIT;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= CTR_BITS'(sat_step(CTR_MAX_BITS'(mem[wr_idx]), wr_up, CTR_BITS));
        end
    end

endmodule

// File: rtl/bht_sat_predictor.sv
// Branch history table with saturating counters; bimodal when HIST_BITS=0, gshare otherwise.
// pred_req and upd_valid have no ready: every cycle either is high is one accepted transaction.
module bht_sat_predictor
    import bht_sat_predictor_pkg::*;
#(
    parameter  int ENTRIES   = 64,
    parameter  int CTR_BITS  = 2,
    parameter  int PC_BITS   = 9,
    parameter  int HIST_BITS = 0,
    localparam int IDX_BITS  = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_BITS-1:0]  pc,
    input  logic                pred_req,
    output logic                pred_valid,
    output logic                prediction,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic                upd_pred,
    output logic [STAT_W-1:0]   total_predictions,
    output logic [STAT_W-1:0]   correct_predictions
);

    logic [IDX_BITS-1:0] hist;
    logic [IDX_BITS-1:0] idx;
    logic [CTR_BITS-1:0] rd_ctr;
    logic [STAT_W-1:0]   total_q;
    logic [STAT_W-1:0]   correct_q;
    logic                unused_pc;

    generate
        if (HIST_BITS > 0) begin : g_gshare
            logic [HIST_BITS-1:0] ghr;
            always_ff @(posedge clk) begin
                if (reset)
                    ghr <= '0;
                else if (upd_valid)
                    ghr <= HIST_BITS'({ghr, upd_taken});
            end
            assign hist = IDX_BITS'(ghr);
        end else begin : g_bimodal
            assign hist = '0;
        end
    endgenerate

    // Upper PC bits do not take part in the hash.
    assign unused_pc = ^pc;
    assign idx       = pc[IDX_BITS-1:0] ^ hist;

    sat_counter_table #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .rd_idx (idx),
        .rd_ctr (rd_ctr),
        .wr_en  (upd_valid),
        .wr_idx (upd_idx),
        .wr_up  (upd_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid <= 1'b0;
            prediction <= 1'b0;
            pred_idx   <= '0;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                prediction <= rd_ctr[CTR_BITS-1];
                pred_idx   <= idx;
            end
        end
    end

    // Both statistics saturate; correct can only move when total moves, keeping correct <= total.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_q   <= '0;
            correct_q <= '0;
        end else if (upd_valid) begin
            if (total_q != '1)
                total_q <= total_q + 1'b1;
            if ((upd_pred == upd_taken) && (correct_q != '1))
                correct_q <= correct_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (correct_q <= total_q);
    end

    assign total_predictions   = total_q;
    assign correct_predictions = correct_q;

endmodule

// File: tb/tb_bht_sat_predictor.sv
// Directed bench for bht_sat_predictor: a bimodal instance and a gshare (HIST_BITS=4)
// instance share one stimulus stream; each scenario task checks its own expectations.
module tb_bht_sat_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  pc = '0;
    logic        pred_req = 1'b0;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred = 1'b0;

    logic        pred_valid, prediction;
    logic [5:0]  pred_idx;
    logic [31:0] total_predictions, correct_predictions;

    logic        gs_pred_valid, gs_prediction;
    logic [5:0]  gs_pred_idx;
    logic [31:0] gs_total, gs_correct;

    int checks = 0;
    int passed = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    bht_sat_predictor dut (
        .clk(clk), .reset(reset), .pc(pc), .pred_req(pred_req),
        .pred_valid(pred_valid), .prediction(prediction), .pred_idx(pred_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .total_predictions(total_predictions), .correct_predictions(correct_predictions)
    );

    bht_sat_predictor #(.HIST_BITS(4)) dut_gs (
        .clk(clk), .reset(reset), .pc(pc), .pred_req(pred_req),
        .pred_valid(gs_pred_valid), .prediction(gs_prediction), .pred_idx(gs_pred_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .total_predictions(gs_total), .correct_predictions(gs_correct)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [5:0] idx, input logic taken, input logic pr);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        upd_pred  = pr;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic do_pred(input logic [8:0] p);
        pred_req = 1'b1;
        pc       = p;
        tick();
        pred_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pred_req = 1'b1; upd_valid = 1'b1; upd_idx = 6'd5; upd_taken = 1'b1; pc = 9'd5;
        tick();
        tick();
        reset = 1'b0; pred_req = 1'b0; upd_valid = 1'b0;
        checks++; if (pred_valid !== 1'b0) $display("FAIL reset_pred_valid got %0h want 0", pred_valid); else passed++;
        checks++; if (prediction !== 1'b0) $display("FAIL reset_prediction got %0h want 0", prediction); else passed++;
        checks++; if (pred_idx !== 6'd0) $display("FAIL reset_pred_idx got %0h want 0", pred_idx); else passed++;
        checks++; if (total_predictions !== 32'd0) $display("FAIL reset_total got %0h want 0", total_predictions); else passed++;
        checks++; if (correct_predictions !== 32'd0) $display("FAIL reset_correct got %0h want 0", correct_predictions); else passed++;
        do_pred(9'd5);
        checks++; if (pred_valid !== 1'b1) $display("FAIL first_pred_valid got %0h want 1", pred_valid); else passed++;
        checks++; if (prediction !== 1'b0) $display("FAIL first_prediction got %0h want 0", prediction); else passed++;
        checks++; if (pred_idx !== 6'd5) $display("FAIL first_pred_idx got %0h want 5", pred_idx); else passed++;
        tick();
        checks++; if (pred_valid !== 1'b0) $display("FAIL idle_pred_valid got %0h want 0", pred_valid); else passed++;
        checks++; if (pred_idx !== 6'd5) $display("FAIL idle_pred_idx_hold got %0h want 5", pred_idx); else passed++;
    endtask

    task automatic test_saturate_high();
        for (int i = 0; i < 3; i++) do_update(6'd5, 1'b1, 1'b0);
        do_pred(9'd5);
        checks++; if (prediction !== 1'b1) $display("FAIL sat3_pred5 got %0h want 1", prediction); else passed++;
        do_update(6'd5, 1'b1, 1'b0);
        do_pred(9'd5);
        checks++; if (prediction !== 1'b1) $display("FAIL sat4_pred5 got %0h want 1", prediction); else passed++;
        do_pred(9'd6);
        checks++; if (prediction !== 1'b0) $display("FAIL sat_pred6 got %0h want 0", prediction); else passed++;
        // 3 -> 2 still taken, 2 -> 1 not taken
        do_update(6'd5, 1'b0, 1'b0);
        do_pred(9'd5);
        checks++; if (prediction !== 1'b1) $display("FAIL dec1_pred5 got %0h want 1", prediction); else passed++;
        do_update(6'd5, 1'b0, 1'b0);
        do_pred(9'd5);
        checks++; if (prediction !== 1'b0) $display("FAIL dec2_pred5 got %0h want 0", prediction); else passed++;
    endtask

    task automatic test_saturate_low();
        for (int i = 0; i < 3; i++) do_update(6'd3, 1'b0, 1'b0);
        do_pred(9'd3);
        checks++; if (prediction !== 1'b0) $display("FAIL floor_pred3 got %0h want 0", prediction); else passed++;
        do_update(6'd3, 1'b1, 1'b0);
        do_pred(9'd3);
        checks++; if (prediction !== 1'b0) $display("FAIL floor_inc1_pred3 got %0h want 0", prediction); else passed++;
        do_update(6'd3, 1'b1, 1'b0);
        do_pred(9'd3);
        checks++; if (prediction !== 1'b1) $display("FAIL floor_inc2_pred3 got %0h want 1", prediction); else passed++;
    endtask

    task automatic test_same_cycle();
        upd_valid = 1'b1; upd_idx = 6'd7; upd_taken = 1'b1; upd_pred = 1'b0;
        pred_req = 1'b1; pc = 9'd7;
        tick();
        upd_valid = 1'b0; pred_req = 1'b0;
        checks++; if (prediction !== 1'b0) $display("FAIL same_cycle_pred7 got %0h want 0", prediction); else passed++;
        do_pred(9'd7);
        checks++; if (prediction !== 1'b1) $display("FAIL after_update_pred7 got %0h want 1", prediction); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] pcs [4];
        logic [0:0] got;
        logic [0:0] want;
        upd_valid = 1'b1; upd_idx = 6'd10; upd_taken = 1'b1; upd_pred = 1'b0;
        tick();
        tick();
        upd_valid = 1'b0;
        do_update(6'd10, 1'b0, 1'b0);
        pcs[0] = 9'd5; pcs[1] = 9'd6; pcs[2] = 9'd7; pcs[3] = 9'd10;
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) begin
            pred_req = 1'b1;
            pc = pcs[i];
            tick();
            got  = prediction;
            want = exp_q.pop_front();
            checks++; if (got !== want) $display("FAIL stream_pred[%0d] got %0h want %0h", i, got, want); else passed++;
            checks++; if (pred_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0h want 1", i, pred_valid); else passed++;
        end
        pred_req = 1'b0;
    endtask

    task automatic test_gshare();
        for (int i = 0; i < 4; i++) do_update(6'd20, 1'b1, 1'b1);
        do_pred(9'h010);
        checks++; if (gs_pred_idx !== 6'h1F) $display("FAIL gshare_idx got %0h want 1f", gs_pred_idx); else passed++;
        checks++; if (pred_idx !== 6'h10) $display("FAIL bimodal_idx got %0h want 10", pred_idx); else passed++;
        do_update(6'd21, 1'b0, 1'b0);
        do_pred(9'h010);
        checks++; if (gs_pred_idx !== 6'h1E) $display("FAIL gshare_idx_nt got %0h want 1e", gs_pred_idx); else passed++;
    endtask

    task automatic test_stats();
        logic [9:0] tk;
        logic [9:0] pr;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tk = 10'b1011001110;
        pr = tk ^ 10'b0100100100;
        for (int i = 0; i < 10; i++) do_update(6'(40 + i), tk[i], pr[i]);
        checks++; if (total_predictions !== 32'd10) $display("FAIL stats_total got %0d want 10", total_predictions); else passed++;
        checks++; if (correct_predictions !== 32'd7) $display("FAIL stats_correct got %0d want 7", correct_predictions); else passed++;
        force dut.total_q = 32'hFFFF_FFFE;
        force dut.correct_q = 32'hFFFF_FFFE;
        #1;
        release dut.total_q;
        release dut.correct_q;
        checks++; if (total_predictions !== 32'hFFFF_FFFE) $display("FAIL preload_total got %0h want fffffffe", total_predictions); else passed++;
        do_update(6'd50, 1'b1, 1'b1);
        do_update(6'd51, 1'b0, 1'b0);
        checks++; if (total_predictions !== 32'hFFFF_FFFF) $display("FAIL sat_total got %0h want ffffffff", total_predictions); else passed++;
        checks++; if (correct_predictions !== 32'hFFFF_FFFF) $display("FAIL sat_correct got %0h want ffffffff", correct_predictions); else passed++;
    endtask

    task automatic test_reset_midstream();
        do_update(6'd3, 1'b1, 1'b1);
        do_pred(9'd3);
        reset = 1'b1; pred_req = 1'b1; pc = 9'd3;
        upd_valid = 1'b1; upd_idx = 6'd3; upd_taken = 1'b1; upd_pred = 1'b1;
        tick();
        reset = 1'b0; pred_req = 1'b0; upd_valid = 1'b0;
        checks++; if (pred_valid !== 1'b0) $display("FAIL mid_reset_valid got %0h want 0", pred_valid); else passed++;
        checks++; if (prediction !== 1'b0) $display("FAIL mid_reset_prediction got %0h want 0", prediction); else passed++;
        checks++; if (pred_idx !== 6'd0) $display("FAIL mid_reset_idx got %0h want 0", pred_idx); else passed++;
        checks++; if (total_predictions !== 32'd0) $display("FAIL mid_reset_total got %0h want 0", total_predictions); else passed++;
        checks++; if (correct_predictions !== 32'd0) $display("FAIL mid_reset_correct got %0h want 0", correct_predictions); else passed++;
        do_pred(9'd3);
        checks++; if (prediction !== 1'b0) $display("FAIL mid_reset_ctr3 got %0h want 0", prediction); else passed++;
        checks++; if (gs_pred_idx !== 6'd3) $display("FAIL mid_reset_ghr_idx got %0h want 3", gs_pred_idx); else passed++;
        do_update(6'd3, 1'b1, 1'b0);
        do_pred(9'd3);
        checks++; if (prediction !== 1'b1) $display("FAIL mid_reset_ctr3_inc got %0h want 1", prediction); else passed++;
        checks++; if (correct_predictions !== 32'd0) $display("FAIL mid_reset_miss_correct got %0h want 0", correct_predictions); else passed++;
    endtask

    initial begin
        test_reset();
        test_saturate_high();
        test_saturate_low();
        test_same_cycle();
        test_back_to_back();
        test_gshare();
        test_stats();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
